// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider controller.
package clk_div_pkg;

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle between the CSR side (master) and clk_div_ctrl (slave).
// Optional macro CLK_DIV_CTRL_ERR_EN adds the err / err_clr pair.
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = clk_div_pkg::DIV_W
) ();

  logic             enable;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             outClk;
  logic             tick;
  logic             busy;
  logic [DIV_W-1:0] cur_div;
`ifdef CLK_DIV_CTRL_ERR_EN
  logic             err;
  logic             err_clr;

  modport master (
    output enable, cfg_valid, cfg_div, err_clr,
    input  cfg_ready, outClk, tick, busy, cur_div, err
  );

  modport slave (
    input  enable, cfg_valid, cfg_div, err_clr,
    output cfg_ready, outClk, tick, busy, cur_div, err
  );
`else
  modport master (
    output enable, cfg_valid, cfg_div,
    input  cfg_ready, outClk, tick, busy, cur_div
  );

  modport slave (
    input  enable, cfg_valid, cfg_div,
    output cfg_ready, outClk, tick, busy, cur_div
  );
`endif

endinterface

// File: rtl/clk_div_core.sv
// Period counter and divided-clock register; a period restarts whenever run rises.
module clk_div_core #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             out_clk,
  output logic             last
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_inc;
  logic             r_run;
  logic             r_out_clk;

  assign w_cnt_inc = r_cnt + DIV_W'(1);
  assign last      = r_run && (r_cnt == (div - DIV_W'(1)));
  assign out_clk   = r_out_clk;

  // Count 0..div-1; high phase is the first div>>1 counts of each period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= 1'b0;
      r_cnt     <= '0;
      r_out_clk <= 1'b0;
    end else begin
      r_run <= run;
      if (!run) begin
        r_cnt     <= '0;
        r_out_clk <= 1'b0;
      end else if (!r_run || last) begin
        r_cnt     <= '0;
        r_out_clk <= 1'b1;
      end else begin
        r_cnt     <= w_cnt_inc;
        r_out_clk <= (w_cnt_inc < (div >> 1));
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio controller for the programmable clock divider.
// Optional macro CLK_DIV_CTRL_ERR_EN: ratios below 2 are dropped and flagged on err.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = clk_div_pkg::DIV_W,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic           inClk,
  input  logic           reset,
  clk_div_ctrl_if.slave  bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_run;
  logic             w_idle;
  logic             w_last;
  logic             w_out_clk;
  logic             w_xfer;
  logic             w_bad;
  logic [DIV_W-1:0] w_div_in;
  logic             w_pend_vld_nxt;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pend_vld;
  logic             r_cfg_ready;
  logic             r_busy;

  // State register.
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: stopping only completes on a period boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.enable) w_state_nxt = RUN;
      RUN:     if (!bus.enable) w_state_nxt = STOP;
      STOP: begin
        if (bus.enable)  w_state_nxt = RUN;
        else if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM decodes feeding the counter and the ratio logic.
  always_comb begin
    w_run  = 1'b0;
    w_idle = 1'b0;
    w_run  = (w_state_nxt != IDLE);
    w_idle = (r_state == IDLE);
  end

  // Qualify the offered ratio: clamp, or mark it for discard when errors are tracked.
  always_comb begin
    w_xfer   = bus.cfg_valid && r_cfg_ready;
    w_bad    = 1'b0;
    w_div_in = bus.cfg_div;
`ifdef CLK_DIV_CTRL_ERR_EN
    w_bad    = (bus.cfg_div < DIV_W'(MIN_DIV));
`else
    if (bus.cfg_div < DIV_W'(MIN_DIV)) w_div_in = DIV_W'(MIN_DIV);
`endif
  end

  // Pending flag: a transfer can only land while pend_vld is clear, so it never collides with a swap.
  always_comb begin
    w_pend_vld_nxt = r_pend_vld;
    if (!w_idle && w_last && r_pend_vld) w_pend_vld_nxt = 1'b0;
    if (!w_idle && w_xfer && !w_bad)     w_pend_vld_nxt = 1'b1;
  end

  // Ratio registers: direct load when idle, otherwise staged until the next boundary.
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      r_cur_div   <= DIV_W'(DEFAULT_DIV);
      r_pend_div  <= DIV_W'(DEFAULT_DIV);
      r_pend_vld  <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      if (w_idle) begin
        if (w_xfer && !w_bad) r_cur_div <= w_div_in;
      end else begin
        if (w_last && r_pend_vld) r_cur_div  <= r_pend_div;
        if (w_xfer && !w_bad)     r_pend_div <= w_div_in;
      end
      r_pend_vld  <= w_pend_vld_nxt;
      r_cfg_ready <= !w_pend_vld_nxt;
    end
  end

  // Registered busy flag tracks the state being entered.
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) r_busy <= 1'b0;
    else       r_busy <= w_run;
  end

`ifdef CLK_DIV_CTRL_ERR_EN
  logic r_err;

  // Sticky error; a new bad ratio outranks a simultaneous clear.
  always_ff @(posedge inClk or posedge reset) begin
    if (reset)                r_err <= 1'b0;
    else if (w_xfer && w_bad) r_err <= 1'b1;
    else if (bus.err_clr)     r_err <= 1'b0;
  end

  assign bus.err = r_err;
`endif

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk     (inClk),
    .rst     (reset),
    .run     (w_run),
    .div     (r_cur_div),
    .out_clk (w_out_clk),
    .last    (w_last)
  );

  assign bus.outClk    = w_out_clk;
  assign bus.tick      = w_last;
  assign bus.busy      = r_busy;
  assign bus.cur_div   = r_cur_div;
  assign bus.cfg_ready = r_cfg_ready;

endmodule
